// File: rtl/stopwatch_ctrl_lap.sv
// stopwatch_ctrl_lap
//   Stopwatch controller. It sits between the debounce/one-pulse stage and the
//   7-segment display mux. A single 4-state FSM (IDLE/RUN/LAP/PAUSE) handles
//   both start/stop and lap/reset. A prescaler produces the count tick. The
//   time is kept as a BCD MM:SS counter. Lap snapshots go into a circular
//   memory that can be read back.
//
// Parameters:
//   TICK_DIV  - clk_100 cycles per count tick
//   MIN_MAX   - largest minute value (0..99)
//   LAP_DEPTH - number of stored laps (power of 2, >= 2)
//   AUTO_STOP - 1: stop at max time, 0: wrap to 00:00
//
// Ports:
//   clk_100      in   system clock
//   rst_n        in   asynchronous active-low reset
//   start_stop_p in   single-cycle start/stop pulse
//   lap_reset_p  in   single-cycle lap/reset pulse
//   lap_rd_idx   in   lap entry to read, 0 = most recent
//   disp_bcd     out  live time, or the frozen lap while in LAP
//   cur_bcd      out  live counter {min_t,min_u,sec_t,sec_u}
//   lap_rd_bcd   out  selected lap entry (registered, 0 if not valid)
//   lap_count    out  number of valid lap entries, saturating at LAP_DEPTH
//   running      out  high in RUN and LAP
//   lap_active   out  high in LAP
//   overflow     out  sticky, set when the count reaches max time
module stopwatch_ctrl_lap #(
    parameter int TICK_DIV  = 100,
    parameter int MIN_MAX   = 59,
    parameter int LAP_DEPTH = 4,
    parameter int AUTO_STOP = 1
) (
    input  logic                         clk_100,
    input  logic                         rst_n,
    input  logic                         start_stop_p,
    input  logic                         lap_reset_p,
    input  logic [$clog2(LAP_DEPTH)-1:0] lap_rd_idx,
    output logic [15:0]                  disp_bcd,
    output logic [15:0]                  cur_bcd,
    output logic [15:0]                  lap_rd_bcd,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         running,
    output logic                         lap_active,
    output logic                         overflow
);

    localparam int IW = $clog2(LAP_DEPTH);
    localparam int CW = IW + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0] MAX_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10), 4'd5, 4'd9};
    localparam logic [CW-1:0] COUNT_FULL = CW'(LAP_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   presc;
    logic [PW-1:0]   presc_nxt;
    logic [15:0]     cnt_nxt;
    logic [15:0]     snap;
    logic [15:0]     lap_mem [LAP_DEPTH];
    logic [IW-1:0]   wr_ptr;
    logic [IW-1:0]   rd_addr;
    logic            rd_valid;
    logic            counting;
    logic            tick;
    logic            capture;
    logic            clear;
    logic            ovf_set;

    // Next-state, tick and BCD increment decode. start_stop_p is tested
    // first in every state, so it wins over lap_reset_p. An auto-stop at
    // max time overrides the pulse decode and also cancels a lap capture.
    always_comb begin
        counting  = (state == RUN) || (state == LAP);
        tick      = counting && (presc == PRESC_LAST);
        state_nxt = state;
        capture   = 1'b0;
        clear     = 1'b0;
        ovf_set   = 1'b0;
        cnt_nxt   = cur_bcd;

        case (state)
            IDLE: begin
                if (start_stop_p) state_nxt = RUN;
            end
            RUN: begin
                if (start_stop_p) begin
                    state_nxt = PAUSE;
                end else if (lap_reset_p) begin
                    state_nxt = LAP;
                    capture   = 1'b1;
                end
            end
            LAP: begin
                if (start_stop_p)     state_nxt = PAUSE;
                else if (lap_reset_p) state_nxt = RUN;
            end
            PAUSE: begin
                if (start_stop_p) begin
                    state_nxt = RUN;
                end else if (lap_reset_p) begin
                    state_nxt = IDLE;
                    clear     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (tick) begin
            if (cur_bcd == MAX_BCD) begin
                ovf_set = 1'b1;
                if (AUTO_STOP != 0) begin
                    state_nxt = PAUSE;
                    capture   = 1'b0;
                end else begin
                    cnt_nxt = 16'h0000;
                end
            end else if (cur_bcd[3:0] != 4'd9) begin
                cnt_nxt[3:0] = cur_bcd[3:0] + 4'd1;
            end else begin
                cnt_nxt[3:0] = 4'd0;
                if (cur_bcd[7:4] != 4'd5) begin
                    cnt_nxt[7:4] = cur_bcd[7:4] + 4'd1;
                end else begin
                    cnt_nxt[7:4] = 4'd0;
                    if (cur_bcd[11:8] != 4'd9) begin
                        cnt_nxt[11:8] = cur_bcd[11:8] + 4'd1;
                    end else begin
                        cnt_nxt[11:8]  = 4'd0;
                        cnt_nxt[15:12] = cur_bcd[15:12] + 4'd1;
                    end
                end
            end
        end

        // The prescaler holds outside RUN/LAP, so a resumed second continues.
        if (tick)          presc_nxt = '0;
        else if (counting) presc_nxt = presc + PW'(1);
        else               presc_nxt = presc;
    end

    // Most recent entry is at wr_ptr-1. The wrap happens naturally because
    // LAP_DEPTH is a power of two.
    always_comb begin
        rd_addr  = wr_ptr - IW'(1) - lap_rd_idx;
        rd_valid = ({1'b0, lap_rd_idx} < lap_count);
    end

    // All state lives here. The IDLE-entry clear comes last, so it overrides
    // the normal updates made on the same edge.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
            presc      <= '0;
            cur_bcd    <= 16'h0000;
            overflow   <= 1'b0;
            snap       <= 16'h0000;
            wr_ptr     <= '0;
            lap_count  <= '0;
            lap_rd_bcd <= 16'h0000;
            for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= 16'h0000;
        end else begin
            state      <= state_nxt;
            running    <= (state_nxt == RUN) || (state_nxt == LAP);
            lap_active <= (state_nxt == LAP);
            presc      <= presc_nxt;
            cur_bcd    <= cnt_nxt;
            if (ovf_set) overflow <= 1'b1;

            // The snapshot is the pre-increment value, even on a tick edge.
            if (capture) begin
                lap_mem[wr_ptr] <= cur_bcd;
                snap            <= cur_bcd;
                wr_ptr          <= wr_ptr + IW'(1);
                if (lap_count != COUNT_FULL) lap_count <= lap_count + CW'(1);
            end

            lap_rd_bcd <= rd_valid ? lap_mem[rd_addr] : 16'h0000;

            if (clear) begin
                cur_bcd   <= 16'h0000;
                presc     <= '0;
                overflow  <= 1'b0;
                wr_ptr    <= '0;
                lap_count <= '0;
                for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= 16'h0000;
            end
        end
    end

    assign disp_bcd = lap_active ? snap : cur_bcd;

endmodule

// File: tb/tb_stopwatch_ctrl_lap.sv
// tb_stopwatch_ctrl_lap
//   Bench for stopwatch_ctrl_lap with TICK_DIV=4, MIN_MAX=1, LAP_DEPTH=4.
//   Two instances share one set of inputs. One has AUTO_STOP=1 and the other
//   has AUTO_STOP=0; they behave the same until max time is reached.
module tb_stopwatch_ctrl_lap;

    logic        clk_100 = 1'b0;
    logic        rst_n;
    logic        start_stop_p;
    logic        lap_reset_p;
    logic [1:0]  lap_rd_idx;

    logic [15:0] disp_bcd, cur_bcd, lap_rd_bcd;
    logic [2:0]  lap_count;
    logic        running, lap_active, overflow;

    logic [15:0] w_disp_bcd, w_cur_bcd, w_lap_rd_bcd;
    logic [2:0]  w_lap_count;
    logic        w_running, w_lap_active, w_overflow;

    int num_compared = 0;
    int num_failed   = 0;

    typedef struct {
        logic        start;
        logic        lap;
        int          wait_cycles;
        logic [15:0] cur;
        logic [15:0] disp;
        logic        run;
        logic        lap_act;
        logic [2:0]  count;
        logic        ovf;
        logic [15:0] rd;
    } vec_t;

    vec_t        vecs [12];
    vec_t        exp_q [$];
    logic [15:0] rd_q [$];
    logic [15:0] rd_exp [4];

    stopwatch_ctrl_lap #(
        .TICK_DIV(4), .MIN_MAX(1), .LAP_DEPTH(4), .AUTO_STOP(1)
    ) dut (
        .clk_100(clk_100), .rst_n(rst_n),
        .start_stop_p(start_stop_p), .lap_reset_p(lap_reset_p),
        .lap_rd_idx(lap_rd_idx),
        .disp_bcd(disp_bcd), .cur_bcd(cur_bcd), .lap_rd_bcd(lap_rd_bcd),
        .lap_count(lap_count), .running(running),
        .lap_active(lap_active), .overflow(overflow)
    );

    stopwatch_ctrl_lap #(
        .TICK_DIV(4), .MIN_MAX(1), .LAP_DEPTH(4), .AUTO_STOP(0)
    ) dut_wrap (
        .clk_100(clk_100), .rst_n(rst_n),
        .start_stop_p(start_stop_p), .lap_reset_p(lap_reset_p),
        .lap_rd_idx(lap_rd_idx),
        .disp_bcd(w_disp_bcd), .cur_bcd(w_cur_bcd), .lap_rd_bcd(w_lap_rd_bcd),
        .lap_count(w_lap_count), .running(w_running),
        .lap_active(w_lap_active), .overflow(w_overflow)
    );

    always #5 clk_100 = ~clk_100;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "[TB] timeout");
    end

    task automatic compare(input string name, input logic [15:0] act, input logic [15:0] want);
        num_compared++;
        if (act !== want) begin
            num_failed++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, want);
        end
    endtask

    // Drives the pulse(s) for one cycle, idles for wait_cycles more, and then
    // queues the expected outputs.
    task automatic apply_stimulus(input vec_t v);
        start_stop_p = v.start;
        lap_reset_p  = v.lap;
        @(negedge clk_100);
        start_stop_p = 1'b0;
        lap_reset_p  = 1'b0;
        repeat (v.wait_cycles) @(negedge clk_100);
        exp_q.push_back(v);
    endtask

    task automatic check_output(input int n);
        vec_t v;
        if (exp_q.size() == 0) begin
            compare($sformatf("v%0d queue", n), 16'd0, 16'd1);
            return;
        end
        v = exp_q.pop_front();
        compare($sformatf("v%0d cur_bcd", n),    cur_bcd,          v.cur);
        compare($sformatf("v%0d disp_bcd", n),   disp_bcd,         v.disp);
        compare($sformatf("v%0d running", n),    16'(running),     16'(v.run));
        compare($sformatf("v%0d lap_active", n), 16'(lap_active),  16'(v.lap_act));
        compare($sformatf("v%0d lap_count", n),  16'(lap_count),   16'(v.count));
        compare($sformatf("v%0d overflow", n),   16'(overflow),    16'(v.ovf));
        compare($sformatf("v%0d lap_rd_bcd", n), lap_rd_bcd,       v.rd);
    endtask

    task automatic pulse(input logic s, input logic l);
        start_stop_p = s;
        lap_reset_p  = l;
        @(negedge clk_100);
        start_stop_p = 1'b0;
        lap_reset_p  = 1'b0;
    endtask

    initial begin
        //            start lap wait  cur      disp     run lapa cnt  ovf  rd
        vecs[0]  = '{1'b0, 1'b0,  0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0,  8, 16'h0002, 16'h0002, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b0, 11, 16'h0005, 16'h0005, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 12, 16'h0008, 16'h0005, 1'b1, 1'b1, 3'd1, 1'b0, 16'h0005};
        vecs[4]  = '{1'b0, 1'b1,  0, 16'h0008, 16'h0008, 1'b1, 1'b0, 3'd1, 1'b0, 16'h0005};
        vecs[5]  = '{1'b1, 1'b0,  5, 16'h0008, 16'h0008, 1'b0, 1'b0, 3'd1, 1'b0, 16'h0005};
        vecs[6]  = '{1'b1, 1'b0,  0, 16'h0008, 16'h0008, 1'b1, 1'b0, 3'd1, 1'b0, 16'h0005};
        vecs[7]  = '{1'b0, 1'b0,  0, 16'h0009, 16'h0009, 1'b1, 1'b0, 3'd1, 1'b0, 16'h0005};
        vecs[8]  = '{1'b1, 1'b0,  0, 16'h0009, 16'h0009, 1'b0, 1'b0, 3'd1, 1'b0, 16'h0005};
        vecs[9]  = '{1'b0, 1'b1,  2, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000};
        vecs[10] = '{1'b1, 1'b0,  4, 16'h0001, 16'h0001, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000};
        vecs[11] = '{1'b1, 1'b1,  0, 16'h0001, 16'h0001, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000};
        rd_exp[0] = 16'h0006;
        rd_exp[1] = 16'h0005;
        rd_exp[2] = 16'h0004;
        rd_exp[3] = 16'h0003;

        rst_n        = 1'b0;
        start_stop_p = 1'b0;
        lap_reset_p  = 1'b0;
        lap_rd_idx   = 2'd0;
        repeat (2) @(negedge clk_100);
        compare("reset cur_bcd", cur_bcd, 16'h0000);
        compare("reset running", 16'(running), 16'd0);
        compare("reset lap_count", 16'(lap_count), 16'd0);
        rst_n = 1'b1;

        // Count from reset, lap snapshot, pause/resume with held prescaler,
        // IDLE clear, simultaneous pulses.
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i]);
            check_output(i);
        end

        // Six laps at values 1..6; each pass through the loop lasts exactly one tick.
        pulse(1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            pulse(1'b0, 1'b1);
            compare($sformatf("lap%0d disp_bcd", k), disp_bcd, 16'(k));
            compare($sformatf("lap%0d lap_active", k), 16'(lap_active), 16'd1);
            compare($sformatf("lap%0d lap_count", k), 16'(lap_count), 16'((k < 4) ? k : 4));
            pulse(1'b0, 1'b1);
            repeat (2) @(negedge clk_100);
        end
        for (int i = 0; i < 4; i++) begin
            lap_rd_idx = 2'(i);
            rd_q.push_back(rd_exp[i]);
            @(negedge clk_100);
            compare($sformatf("lap_rd idx%0d", i), lap_rd_bcd, rd_q.pop_front());
        end
        lap_rd_idx = 2'd0;

        // Overflow: 119 ticks reach 01:59, and the next tick is the overflow tick.
        rst_n = 1'b0;
        @(negedge clk_100);
        rst_n = 1'b1;
        pulse(1'b1, 1'b0);
        repeat (476) @(negedge clk_100);
        compare("pre-max cur_bcd", cur_bcd, 16'h0159);
        compare("pre-max overflow", 16'(overflow), 16'd0);
        compare("pre-max wrap cur_bcd", w_cur_bcd, 16'h0159);
        repeat (4) @(negedge clk_100);
        compare("autostop cur_bcd", cur_bcd, 16'h0159);
        compare("autostop running", 16'(running), 16'd0);
        compare("autostop overflow", 16'(overflow), 16'd1);
        compare("wrap cur_bcd", w_cur_bcd, 16'h0000);
        compare("wrap running", 16'(w_running), 16'd1);
        compare("wrap overflow", 16'(w_overflow), 16'd1);
        repeat (4) @(negedge clk_100);
        compare("autostop held cur_bcd", cur_bcd, 16'h0159);
        compare("wrap next cur_bcd", w_cur_bcd, 16'h0001);
        compare("wrap sticky overflow", 16'(w_overflow), 16'd1);
        pulse(1'b0, 1'b1);
        compare("idle clears overflow", 16'(overflow), 16'd0);
        compare("idle clears cur_bcd", cur_bcd, 16'h0000);

        // Out-of-range read, then an asynchronous reset in the middle of LAP.
        pulse(1'b1, 1'b0);
        repeat (8) @(negedge clk_100);
        pulse(1'b0, 1'b1);
        lap_rd_idx = 2'd2;
        @(negedge clk_100);
        compare("lap_rd idx>=count", lap_rd_bcd, 16'h0000);
        lap_rd_idx = 2'd0;
        @(negedge clk_100);
        compare("mid-lap lap_rd_bcd", lap_rd_bcd, 16'h0002);
        compare("mid-lap disp_bcd", disp_bcd, 16'h0002);
        compare("mid-lap lap_active", 16'(lap_active), 16'd1);
        #1 rst_n = 1'b0;
        #1;
        compare("async cur_bcd", cur_bcd, 16'h0000);
        compare("async disp_bcd", disp_bcd, 16'h0000);
        compare("async lap_rd_bcd", lap_rd_bcd, 16'h0000);
        compare("async lap_count", 16'(lap_count), 16'd0);
        compare("async running", 16'(running), 16'd0);
        compare("async lap_active", 16'(lap_active), 16'd0);
        compare("async overflow", 16'(overflow), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_failed);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl_lap.md
Name: stopwatch_ctrl_lap

Overview:
Parametrised stopwatch controller that succeeds the two-toggle start/stop and lap state pair.
- Merges start/stop and lap/reset into one 4-state FSM.
- Adds a 1 s timebase prescaler, a BCD MM:SS counter with overflow handling, and a circular lap memory with read-back.
- Sits between the debounce/one-pulse stage and the 7-segment display mux.

Parameters:
TICK_DIV, 100, clk_100 cycles per count tick (100 gives 1 s at 100 Hz).
MIN_MAX, 59, largest minute value (0..99).
LAP_DEPTH, 4, number of stored lap entries (power of 2, ≥2).
AUTO_STOP, 1, 1 = stop at max time; 0 = wrap to 00:00.

Ports:
clk_100  in  1  system clock.
rst_n  in  1  asynchronous, active-low reset.
start_stop_p  in  1  debounced single-cycle start/stop pulse.
lap_reset_p  in  1  debounced single-cycle lap/reset pulse.
lap_rd_idx  in  log2(LAP_DEPTH)  lap entry to read; 0 = most recent.
disp_bcd  out  16  {min_t,min_u,sec_t,sec_u}; live time, or the frozen lap in LAP.
cur_bcd  out  16  live counter value.
lap_rd_bcd  out  16  stored lap entry selected by lap_rd_idx (registered).
lap_count  out  log2(LAP_DEPTH)+1  number of valid entries, saturating at LAP_DEPTH.
running  out  1  high in RUN and LAP.
lap_active  out  1  high in LAP.
overflow  out  1  sticky; set when the count reaches max time.

Behaviour:
Reset:
- State = IDLE.
- Every output, the counter, the prescaler, the lap memory and the write pointer are 0.

FSM transitions (registered; the new state is visible the cycle after the pulse):
- IDLE: start_stop_p → RUN; lap_reset_p ignored.
- RUN: start_stop_p → PAUSE; lap_reset_p → LAP and capture the snapshot.
- LAP: start_stop_p → PAUSE (display goes live again); lap_reset_p → RUN (display goes live, no capture).
- PAUSE: start_stop_p → RUN; lap_reset_p → IDLE.
- Both pulses in the same cycle: start_stop_p wins and lap_reset_p is dropped.

Entering IDLE (from PAUSE) clears, on the same edge: counter, prescaler, overflow, lap memory, write pointer, lap_count.

Prescaler:
- Increments only in RUN and LAP; range 0..TICK_DIV-1.
- The cycle it equals TICK_DIV-1 is a tick: prescaler returns to 0 and the counter advances on that same edge.
- Holds its value in PAUSE, so a resumed second is not lost or restarted.

Counter:
- BCD, sec_u 0-9, sec_t 0-5, minutes 00..MIN_MAX.
- 59 s rolls to 00 s with a minute carry.
- On the tick at MIN_MAX:59:
  - AUTO_STOP=1: counter holds at MIN_MAX:59, state → PAUSE, overflow=1.
  - AUTO_STOP=0: counter wraps to 00:00, state unchanged, overflow=1.
- overflow stays set until IDLE.

Lap capture (RUN→LAP):
- Snapshot = cur_bcd value at the capture edge. If a tick coincides, the snapshot is the pre-increment value.
- The snapshot is written to lap memory at the write pointer.
- Write pointer increments mod LAP_DEPTH; when full, the oldest entry is overwritten.
- lap_count increments, saturating at LAP_DEPTH.
- disp_bcd holds the snapshot throughout LAP; everywhere else disp_bcd = cur_bcd.

Lap read-back:
- lap_rd_bcd = entry at (wr_ptr-1-lap_rd_idx) mod LAP_DEPTH, registered with 1-cycle latency.
- When lap_rd_idx ≥ lap_count, lap_rd_bcd = 0.

Reset mid-operation: asynchronous return to the reset values above, in any state.

Test Plan:
- Reset, start_stop_p, 2×TICK_DIV cycles (TICK_DIV=4) → running=1, cur_bcd=0x0002, disp_bcd=0x0002.
- RUN at 0x0005, lap_reset_p, run 3 more ticks → lap_active=1, disp_bcd=0x0005, cur_bcd=0x0008; lap_reset_p again → disp_bcd=0x0008, lap_count=1, lap_rd_bcd(idx0)=0x0005.
- Pause with prescaler=2, resume, count cycles → next tick after 1 cycle (prescaler keeps its value); then PAUSE + lap_reset_p → IDLE with cur_bcd=0, lap_count=0, overflow=0.
- MIN_MAX=1, AUTO_STOP=1, run to 01:59 then one more tick → cur_bcd=0x0159, state PAUSE, overflow=1. Same with AUTO_STOP=0 → cur_bcd=0x0000, running=1, overflow=1.
- 6 laps at values 1..6 with LAP_DEPTH=4 → lap_count=4; idx0..3 read 0x0006, 0x0005, 0x0004, 0x0003.
- Simultaneous start_stop_p and lap_reset_p in RUN → PAUSE, no lap captured. Assert rst_n low mid-LAP → all outputs 0 asynchronously.
